// File: rtl/raster_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// raster_cmd_sequencer
//
// Arbitrates between two command requesters (round-robin on ties), optionally
// holds the accepted command until the next frame_sync, then serializes it as
// an opcode byte plus parameter bytes on consecutive cycles, followed by
// GAP_CYCLES idle cycles so the downstream command processor can finish its
// EXECUTE state before the next opcode arrives.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   reqN_valid/cmd      requester N presents a 16-bit command word
//   reqN_ready          combinational; handshake when valid && ready
//   frame_sync          single-cycle frame pulse
//   ui_out              registered command byte {en, cmd[1:0], param[4:0]}
//   busy                registered; high whenever the FSM is not IDLE
//   grant               registered; requester owning the current/last command
//
// Command word: [15] wait_frame, [14:13] op (01 pixel, 10 line, 11 rect,
// 00 invalid), [12] clear (pixel only), [11:9] a, [8:6] b, [5:3] c, [2:0] d.
// -----------------------------------------------------------------------------
module raster_cmd_sequencer #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_cmd,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_cmd,
  output logic        req1_ready,
  input  logic        frame_sync,
  output logic [7:0]  ui_out,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_SEND       = 2'd2,
    S_GAP        = 2'd3
  } state_t;

  localparam logic [2:0] GAP_INIT = 3'(GAP_CYCLES);

  state_t      state, state_nxt;
  logic [14:0] cmd_p0, cmd_nxt;
  logic [1:0]  byte_idx, byte_idx_nxt;
  logic [2:0]  gap_cnt, gap_cnt_nxt;
  logic        last_served, last_served_nxt;
  logic        grant_nxt, busy_nxt;
  logic [7:0]  ui_nxt;
  logic        pick;
  logic        hs;
  logic [15:0] hs_cmd;

  // Byte idx of a command: opcode byte at 0, parameters b/c/d at 1..3.
  // A pixel with clear set collapses to the fixed clear opcode 0xBF.
  function automatic logic [7:0] cmd_byte(input logic [14:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    cmd_byte = (w[14:13] == 2'b01 && w[12]) ? 8'hBF
                                                       : {1'b1, w[14:13], 2'b00, w[11:9]};
      2'd1:    cmd_byte = {5'b10000, w[8:6]};
      2'd2:    cmd_byte = {5'b10000, w[5:3]};
      default: cmd_byte = {5'b10000, w[2:0]};
    endcase
  endfunction

  // Index of the final byte: clear 0, pixel 1, line/rect 3.
  function automatic logic [1:0] last_idx(input logic [2:0] op_clr);
    if (op_clr[2:1] == 2'b01)
      last_idx = op_clr[0] ? 2'd0 : 2'd1;
    else
      last_idx = 2'd3;
  endfunction

  // Single requester wins outright; on a tie the one not served last wins.
  always_comb begin
    if (req0_valid && req1_valid)
      pick = ~last_served;
    else
      pick = req1_valid;
  end

  assign req0_ready = (state == S_IDLE) && req0_valid && !pick;
  assign req1_ready = (state == S_IDLE) && req1_valid && pick;
  assign hs         = req0_ready || req1_ready;
  assign hs_cmd     = pick ? req1_cmd : req0_cmd;

  always_comb begin
    state_nxt       = state;
    cmd_nxt         = cmd_p0;
    byte_idx_nxt    = byte_idx;
    gap_cnt_nxt     = gap_cnt;
    last_served_nxt = last_served;
    grant_nxt       = grant;
    ui_nxt          = 8'h00;
    case (state)
      S_IDLE: begin
        if (hs) begin
          cmd_nxt         = hs_cmd[14:0];
          grant_nxt       = pick;
          last_served_nxt = pick;
          // Invalid op is consumed silently: no bytes, no gap.
          if (hs_cmd[14:13] != 2'b00) begin
            if (hs_cmd[15]) begin
              state_nxt = S_WAIT_FRAME;
            end else begin
              state_nxt    = S_SEND;
              byte_idx_nxt = 2'd0;
              ui_nxt       = cmd_byte(hs_cmd[14:0], 2'd0);
            end
          end
        end
      end
      S_WAIT_FRAME: begin
        if (frame_sync) begin
          state_nxt    = S_SEND;
          byte_idx_nxt = 2'd0;
          ui_nxt       = cmd_byte(cmd_p0, 2'd0);
        end
      end
      S_SEND: begin
        if (byte_idx == last_idx(cmd_p0[14:12])) begin
          state_nxt    = S_GAP;
          byte_idx_nxt = 2'd0;
          gap_cnt_nxt  = GAP_INIT;
        end else begin
          byte_idx_nxt = byte_idx + 2'd1;
          ui_nxt       = cmd_byte(cmd_p0, byte_idx + 2'd1);
        end
      end
      S_GAP: begin
        gap_cnt_nxt = gap_cnt - 3'd1;
        if (gap_cnt <= 3'd1) begin
          state_nxt   = S_IDLE;
          gap_cnt_nxt = 3'd0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_idx    <= 2'd0;
      gap_cnt     <= 3'd0;
      last_served <= 1'b1;
      grant       <= 1'b0;
      busy        <= 1'b0;
      ui_out      <= 8'h00;
    end else begin
      state       <= state_nxt;
      byte_idx    <= byte_idx_nxt;
      gap_cnt     <= gap_cnt_nxt;
      last_served <= last_served_nxt;
      grant       <= grant_nxt;
      busy        <= busy_nxt;
      ui_out      <= ui_nxt;
    end
  end

  // Latched command word is pure data; its contents only matter once the
  // FSM has left IDLE, so it carries no reset.
  always_ff @(posedge clk) begin
    cmd_p0 <= cmd_nxt;
  end

endmodule

// File: tb/tb_raster_cmd_sequencer.sv
module tb_raster_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_cmd = 16'h0000;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_cmd = 16'h0000;
  logic        frame_sync = 1'b0;

  logic        req0_ready, req1_ready, busy, grant;
  logic [7:0]  ui_out;
  logic        r0_3, r1_3, busy3, grant3;
  logic [7:0]  ui3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  raster_cmd_sequencer #(.GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .frame_sync(frame_sync), .ui_out(ui_out), .busy(busy), .grant(grant)
  );

  raster_cmd_sequencer #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(r0_3),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(r1_3),
    .frame_sync(frame_sync), .ui_out(ui3), .busy(busy3), .grant(grant3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Returns at the negedge of the handshake cycle.
  task automatic wait_ready(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which == 0 && req0_ready) || (which == 1 && req1_ready) || (which == 2 && r0_3)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++; if (ui_out !== 8'h00) begin bad++; $display("FAIL reset_ui got=%h want=00", ui_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant !== 1'b0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant); end
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_cmd = 16'h0000;
    req1_valid = 1'b1; req1_cmd = 16'h0000;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL reset_tie_r0 got=%b want=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_tie_r1 got=%b want=0", req1_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    total++; if (ui_out !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL reset_invalid_idle got=%h/%b want=00/0", ui_out, busy); end
    step();
  endtask

  task automatic test_pixel();
    bit ok;
    req0_cmd = 16'h2740; req0_valid = 1'b1;
    wait_ready(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL pixel_hs got=timeout want=ready"); end
    step(); req0_valid = 1'b0;
    @(negedge clk);
    total++; if (ui_out !== 8'hA3) begin bad++; $display("FAIL pixel_b0 got=%h want=a3", ui_out); end
    total++; if (busy !== 1'b1 || grant !== 1'b0) begin bad++; $display("FAIL pixel_busy_grant got=%b/%b want=1/0", busy, grant); end
    step(); @(negedge clk);
    total++; if (ui_out !== 8'h85) begin bad++; $display("FAIL pixel_b1 got=%h want=85", ui_out); end
    step(); @(negedge clk);
    total++; if (ui_out !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL pixel_gap got=%h/%b want=00/1", ui_out, busy); end
    step(); req0_valid = 1'b1; req0_cmd = 16'h0123;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL pixel_ready_t4 got=%b/%b want=1/0", req0_ready, busy); end
    step(); @(negedge clk);
    total++; if (req0_ready !== 1'b1 || ui_out !== 8'h00 || busy !== 1'b0) begin
      bad++; $display("FAIL invalid_op got=r%b ui%h b%b want=r1 ui00 b0", req0_ready, ui_out, busy);
    end
    step(); req0_valid = 1'b0;
  endtask

  task automatic test_clear_line();
    bit ok;
    logic [7:0] exp [9];
    exp = '{8'hBF, 8'h00, 8'h00, 8'hC1, 8'h82, 8'h86, 8'h87, 8'h00, 8'h00};
    req0_cmd = 16'h3000; req0_valid = 1'b1;
    wait_ready(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL clear_hs got=timeout want=ready"); end
    step(); req0_cmd = 16'h42B7;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) req0_valid = 1'b0;
      @(negedge clk);
      total++; if (ui_out !== exp[i]) begin bad++; $display("FAIL clear_line_seq[%0d] got=%h want=%h", i, ui_out, exp[i]); end
      if (i < 3) begin
        total++; if (req0_ready !== (i == 2)) begin bad++; $display("FAIL clear_line_ready[%0d] got=%b want=%b", i, req0_ready, (i == 2)); end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int n_hs = 0;
    int n_b0 = 0;
    bit both = 1'b0;
    bit ord [8];
    logic [7:0] b0 [8];
    bit gr [8];
    do_reset();
    req0_cmd = 16'h6400; req1_cmd = 16'h6800;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both = 1'b1;
      if ((req0_ready || req1_ready) && n_hs < 8) begin ord[n_hs] = req1_ready; n_hs++; end
      if (ui_out[7] && ui_out[6:5] != 2'b00 && n_b0 < 8) begin b0[n_b0] = ui_out; gr[n_b0] = grant; n_b0++; end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (n_hs != 5 || n_b0 != 5) begin bad++; $display("FAIL rr_counts got=%0d/%0d want=5/5", n_hs, n_b0); end
    total++; if (both) begin bad++; $display("FAIL rr_both_ready got=1 want=0"); end
    for (int k = 0; k < 4; k++) begin
      if (k < n_hs && k < n_b0) begin
        total++; if (ord[k] !== k[0]) begin bad++; $display("FAIL rr_order[%0d] got=%b want=%b", k, ord[k], k[0]); end
        total++; if (b0[k] !== (k[0] ? 8'hE4 : 8'hE2)) begin bad++; $display("FAIL rr_byte0[%0d] got=%h want=%h", k, b0[k], (k[0] ? 8'hE4 : 8'hE2)); end
        total++; if (gr[k] !== k[0]) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, gr[k], k[0]); end
      end
    end
  endtask

  task automatic test_wait_frame();
    bit ok;
    do_reset();
    req0_cmd = 16'hA740; req0_valid = 1'b1; frame_sync = 1'b1;
    wait_ready(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL wf_hs got=timeout want=ready"); end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) begin frame_sync = 1'b0; req0_valid = 1'b0; end
      if (i == 10) frame_sync = 1'b1;
      @(negedge clk);
      total++; if (ui_out !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL wf_hold[%0d] got=%h/%b want=00/1", i, ui_out, busy); end
    end
    step(); frame_sync = 1'b0;
    @(negedge clk);
    total++; if (ui_out !== 8'hA3) begin bad++; $display("FAIL wf_b0 got=%h want=a3", ui_out); end
    step(); @(negedge clk);
    total++; if (ui_out !== 8'h85) begin bad++; $display("FAIL wf_b1 got=%h want=85", ui_out); end
    step(); @(negedge clk);
    total++; if (ui_out !== 8'h00) begin bad++; $display("FAIL wf_gap got=%h want=00", ui_out); end
    step(); @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wf_idle got=%b want=0", busy); end
    step();
  endtask

  task automatic test_gap3();
    bit ok;
    logic [7:0] exp [8];
    exp = '{8'hC1, 8'h82, 8'h86, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    req0_cmd = 16'h42B7; req0_valid = 1'b1;
    wait_ready(2, ok);
    total++; if (!ok) begin bad++; $display("FAIL gap3_hs got=timeout want=ready"); end
    step(); req0_cmd = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (ui3 !== exp[i]) begin bad++; $display("FAIL gap3_ui[%0d] got=%h want=%h", i, ui3, exp[i]); end
      total++; if (r0_3 !== (i == 7)) begin bad++; $display("FAIL gap3_ready[%0d] got=%b want=%b", i, r0_3, (i == 7)); end
      total++; if (busy3 !== (i < 7)) begin bad++; $display("FAIL gap3_busy[%0d] got=%b want=%b", i, busy3, (i < 7)); end
      step();
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    req1_cmd = 16'h42B7; req1_valid = 1'b1;
    wait_ready(1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_hs got=timeout want=ready"); end
    step(); req1_valid = 1'b0;
    @(negedge clk);
    total++; if (ui_out !== 8'hC1 || grant !== 1'b1) begin bad++; $display("FAIL rmid_b0 got=%h/%b want=c1/1", ui_out, grant); end
    step(); @(negedge clk);
    total++; if (ui_out !== 8'h82) begin bad++; $display("FAIL rmid_b1 got=%h want=82", ui_out); end
    #1 rst = 1'b1;
    #1;
    total++; if (ui_out !== 8'h00 || busy !== 1'b0 || grant !== 1'b0) begin
      bad++; $display("FAIL rmid_abort got=%h/%b/%b want=00/0/0", ui_out, busy, grant);
    end
    step(); rst = 1'b0;
    req0_cmd = 16'h2740; req0_valid = 1'b1;
    wait_ready(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_pix_hs got=timeout want=ready"); end
    step(); req0_valid = 1'b0;
    @(negedge clk);
    total++; if (ui_out !== 8'hA3) begin bad++; $display("FAIL rmid_pix_b0 got=%h want=a3", ui_out); end
    step(); @(negedge clk);
    total++; if (ui_out !== 8'h85) begin bad++; $display("FAIL rmid_pix_b1 got=%h want=85", ui_out); end
    step(); @(negedge clk);
    total++; if (ui_out !== 8'h00) begin bad++; $display("FAIL rmid_pix_gap got=%h want=00", ui_out); end
    step();
    req0_cmd = 16'h1FFF; req0_valid = 1'b1;
    wait_ready(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_op0_hs got=timeout want=ready"); end
    step(); req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (ui_out !== 8'h00 || busy !== 1'b0 || grant !== 1'b0) begin
        bad++; $display("FAIL rmid_op0[%0d] got=%h/%b/%b want=00/0/0", i, ui_out, busy, grant);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_clear_line();
    test_round_robin();
    test_wait_frame();
    test_gap3();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/raster_cmd_sequencer.md
# raster_cmd_sequencer

Two-requester command arbiter and serializer that sits directly upstream of the rasterizer command processor and drives its 8-bit command byte input. Each requester hands over one complete drawing command as a packed word. The block arbitrates round-robin and optionally holds the command until the next frame_sync. It then emits the opcode byte plus parameter bytes on consecutive cycles, followed by idle gap cycles so the processor's EXECUTE state completes before the next opcode arrives.

## Interface
- GAP_CYCLES, 1: idle (en=0) cycles after the last byte of each command; legal range 1..7.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 presents a command.
- req0_cmd  in  16  requester 0 command word (format below).
- req0_ready  out  1  combinational; handshake completes when valid && ready.
- req1_valid, req1_cmd, req1_ready: same as requester 0, for requester 1.
- frame_sync  in  1  single-cycle frame pulse from the rasterizer.
- ui_out  out  8  registered byte to the command processor: [7]=en, [6:5]=cmd, [4:0]=param.
- busy  out  1  registered; high in every state except IDLE.
- grant  out  1  registered; index of the requester owning the current or last command.

## Operation
- Command word fields:
  - [15] wait_frame.
  - [14:13] op: 01 pixel, 10 line, 11 rect, 00 invalid.
  - [12] clear: meaningful only for op 01.
  - [11:9] a (x1), [8:6] b (y1), [5:3] c (x2 or width), [2:0] d (y2 or height).
- States: IDLE, WAIT_FRAME, SEND, GAP.
- IDLE:
  - readyN = (state==IDLE) && reqN_valid && (arbiter picks N).
  - Arbiter: with one requester valid, that requester wins. With both valid, the winner is the requester not equal to last_served.
  - last_served resets to 1, so requester 0 wins the first tie.
- On handshake:
  - Latch the word, set grant and last_served.
  - Next state:
    - op==00: stays IDLE. The word is dropped, no bytes are emitted, and no gap is inserted.
    - wait_frame=1: WAIT_FRAME.
    - Otherwise: SEND with byte index 0; byte 0 is loaded into ui_out on the same edge.
- WAIT_FRAME:
  - ui_out=0.
  - When frame_sync=1 is sampled in this state, byte 0 is loaded and the state moves to SEND.
  - A frame_sync in the handshake cycle is ignored.
- Byte encodings:
  - byte0, normal: {1, op, 2'b00, a}.
  - byte0, op 01 with clear=1: 0xBF, i.e. {1,01,11111}.
  - byte1: {1,00,00,b}. byte2: {1,00,00,c}. byte3: {1,00,00,d}.
- Byte count: clear=1, 1; pixel, 2; line/rect, 4. The clear bit is ignored for op 10/11.
- SEND: emits one byte per cycle. After the last byte, ui_out=0 and the state moves to GAP with a counter of GAP_CYCLES.
- GAP:
  - ui_out=0; the counter decrements each cycle.
  - The state returns to IDLE on the edge that ends the GAP_CYCLES-th gap cycle.
  - A new handshake is possible in the first IDLE cycle.
- Requesters may change or drop valid at any time without affecting a latched command.
- Reset mid-command aborts the command immediately; no bytes are resumed.
  - The processor receives en=0 and falls back to its idle state.

## Timing
- Reset values: ui_out=0x00, busy=0, grant=0, state=IDLE, last_served=1, byte index=0, gap counter=0.
- readyN may be high in the first cycle after rst deasserts.
- Pixel command with GAP_CYCLES=1:
  - Handshake in cycle T.
  - byte0 in T+1, byte1 in T+2.
  - 0x00 in T+3.
  - IDLE and ready in T+4.
- Line/rect: bytes in T+1..T+4, gap in T+5, ready in T+6.
- Clear: byte in T+1, gap in T+2, ready in T+3.
- Invalid op: ready may assert again in T+1.
- Each added GAP_CYCLES adds one cycle.
- wait_frame: if frame_sync is sampled high in cycle F (F>T), byte0 appears in F+1.
- busy rises in T+1 and falls in the first IDLE cycle.

## Test plan
- Pixel, a=3, b=5, from req0 after reset:
  - ui_out 0xA3 then 0x85, then 0x00.
  - req0_ready is high again 4 cycles after the handshake; grant=0.
- Clear (op 01, clear=1) followed by line a=1, b=2, c=6, d=7:
  - ui_out 0xBF, 0x00.
  - Then 0xC1, 0x82, 0x86, 0x87, 0x00; never two non-zero commands without a gap.
- Both requesters continuously valid with rect words (a=2 and a=4):
  - Order is req0, req1, req0, req1.
  - byte0 alternates 0xE2 / 0xE4.
  - Neither requester is starved.
- wait_frame=1 pixel, frame_sync pulsed in the handshake cycle and again 10 cycles later:
  - The first pulse is ignored.
  - 0xA? appears exactly one cycle after the second pulse.
- GAP_CYCLES=3 build with a line command: exactly three 0x00 cycles between the last byte and the next possible ready.
- rst asserted during byte1 of a line command:
  - ui_out is 0x00 immediately.
  - busy=0 and grant=0.
  - After release, a new pixel is emitted normally.
  - An op 00 word is accepted with no output.
